// File: rtl/mips_ex_pkg.sv
// Shared EX-stage constants: HI/LO read selects, divider state encoding
// and the divide latency seen by ALU control.
package mips_ex_pkg;

  localparam logic [1:0] HILO_HI   = 2'b00;
  localparam logic [1:0] HILO_LO   = 2'b01;
  localparam logic [1:0] HILO_NONE = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam int unsigned DIV_CYCLES = 33;

endpackage

// File: rtl/divu_step.sv
// One combinational restoring-division iteration on {rem, quo}.
module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // Since rem < divisor is kept invariant, the top bit of trial is a clean sign bit.
  assign rem_sh = {rem_i, quo_i[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, divisor_i};
  assign rem_o  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_o  = {quo_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/divu_hilo_unit.sv
// Multi-cycle unsigned divider feeding the HI/LO registers, with mfhi/mflo
// read mux and a stall while a division is in flight.
module divu_hilo_unit
  import mips_ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [1:0]       hilo_sel,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             done,
  output logic             hilo_stall,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic             rd_req;

  divu_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (div_start) begin
          state_d = ST_RUN;
          rem_d   = '0;
          quo_d   = dividend;
          dvsr_d  = divisor;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        hi_d    = rem_q;
        lo_d    = quo_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    case (hilo_sel)
      HILO_HI: hilo_out = hi_q;
      HILO_LO: hilo_out = lo_q;
      default: hilo_out = '0;
    endcase
  end

  // Bit 1 of the select marks "no HI/LO read" (10 and 11).
  assign rd_req     = (hilo_sel & HILO_NONE) == 2'b00;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_COMMIT);
  assign hilo_stall = busy & rd_req;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_divu_hilo_unit.sv
// Directed + randomized bench for divu_hilo_unit against a plain-arithmetic model.
module tb_divu_hilo_unit;
  import mips_ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [1:0]  hilo_sel;
  logic [31:0] hilo_out;
  logic        busy;
  logic        done;
  logic        hilo_stall;
  logic [1:0]  dbg_state;

  int passed = 0;
  int failed = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  divu_hilo_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start),
    .dividend   (dividend),
    .divisor    (divisor),
    .hilo_sel   (hilo_sel),
    .hilo_out   (hilo_out),
    .busy       (busy),
    .done       (done),
    .hilo_stall (hilo_stall),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [1:0] sel);
    if (sel == 2'b00) return exp_hi;
    if (sel == 2'b01) return exp_lo;
    return 32'h0;
  endfunction

  // Issue a divide at the current negedge and follow it until busy drops.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                        input int abort_at, input int repulse_at);
    int cycles = 0;
    int dones  = 0;
    exp_q.push_back((b == 0) ? 32'hFFFF_FFFF : a / b);
    exp_q.push_back((b == 0) ? a : a % b);
    div_start = 1'b1;
    dividend  = a;
    divisor   = b;
    hilo_sel  = sel;
    @(negedge clk);
    div_start = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      if (done === 1'b1) dones++;
      check("stall_busy", {31'b0, hilo_stall}, {31'b0, sel[1] == 1'b0});
      check("stale_read", hilo_out, exp_read(sel));
      div_start = (cycles == repulse_at);
      if (cycles == repulse_at) begin
        dividend = a + 32'd123;
        divisor  = b + 32'd3;
      end
      if (cycles == abort_at) rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      div_start = 1'b0;
    end
    if (abort_at > 0) begin
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      exp_hi = '0;
      exp_lo = '0;
      check("abort_cycles", cycles, abort_at);
      check("abort_no_done", dones, 0);
    end else begin
      exp_lo = exp_q.pop_front();
      exp_hi = exp_q.pop_front();
      check("busy_cycles", cycles, DIV_CYCLES);
      check("done_pulses", dones, 1);
    end
    check("idle_done", {31'b0, done}, 32'h0);
    hilo_sel = HILO_LO;
    #1 check("read_lo", hilo_out, exp_lo);
    hilo_sel = HILO_HI;
    #1 check("read_hi", hilo_out, exp_hi);
    check("idle_stall", {31'b0, hilo_stall}, 32'h0);
    hilo_sel = HILO_NONE;
    #1 check("read_none", hilo_out, 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    div_start = 1'b1;
    dividend  = 32'd100;
    divisor   = 32'd7;
    hilo_sel  = HILO_HI;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    div_start = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_stall", {31'b0, hilo_stall}, 32'h0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    check("rst_hi", hilo_out, 32'h0);
    hilo_sel = HILO_LO;
    #1 check("rst_lo", hilo_out, 32'h0);
    @(negedge clk);
    check("rst_start_ignored", {31'b0, busy}, 32'h0);

    do_div(32'd100, 32'd7, 2'b01, 0, 0);
    check("t100_7_lo", exp_lo, 32'd14);
    do_div(32'hFFFF_FFFF, 32'd1, 2'b00, 0, 0);
    do_div(32'd5, 32'h8000_0000, 2'b10, 0, 0);
    do_div(32'h1234, 32'd0, 2'b00, 0, 0);
    do_div(32'd1000, 32'd3, 2'b01, 10, 0);
    do_div(32'd9, 32'd2, 2'b00, 0, 0);
    do_div(32'd50, 32'd5, 2'b11, 0, 5);
    do_div(32'd7, 32'd2, 2'b01, 0, 0);

    for (int i = 0; i < 12; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 15);
      else b = $urandom >> $urandom_range(0, 31);
      do_div(a, b, 2'($urandom_range(0, 3)), 0, 0);
    end

    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end

endmodule

// File: doc/divu_hilo_unit.md
# divu_hilo_unit

Multi-cycle unsigned divider and HI/LO register file for the EX stage. It consumes the divide-start and HI/LO-select decodes produced by ALU control. It executes `divu` over a fixed 33-cycle sequence, writing the quotient to LO and the remainder to HI. It serves `mfhi`/`mflo` reads and raises a pipeline stall while a division is in flight.

## Interface
Parameters:
- `WIDTH`, default 32: operand, HI and LO width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `div_start`  in  1  divide request (`DIVOperation`); sampled only in IDLE.
- `dividend`  in  WIDTH  rs operand, unsigned.
- `divisor`  in  WIDTH  rt operand, unsigned.
- `hilo_sel`  in  2  read select (`HILOOperation`): 00 = HI, 01 = LO, 10 and 11 = none.
- `hilo_out`  out  WIDTH  selected HI/LO value.
- `busy`  out  1  division in progress.
- `done`  out  1  one-cycle pulse when HI/LO have just been committed.
- `hilo_stall`  out  1  the current read must wait.

## Operation
- State machine:
  - IDLE to RUN on `div_start`. Latch the dividend into the quotient shift register, latch the divisor, clear the partial remainder, and set `cnt`=0.
  - RUN: each cycle performs one restoring step.
    - Shift `{rem,quo}` left by 1.
    - Trial = rem − divisor, computed WIDTH+1 bits wide.
    - If trial ≥ 0: rem = trial and the new quotient LSB = 1. Otherwise rem is unchanged and the LSB = 0.
    - `cnt`++. After WIDTH steps, go to COMMIT.
  - COMMIT: HI ← rem, LO ← quo, `done`=1 for this cycle only, then go to IDLE.
- Divide by zero has no special path. The algorithm naturally yields LO = all-ones and HI = dividend; this is the defined result.
- `div_start` during RUN or COMMIT is ignored. It is not queued, and operand regs are not reloaded.
- `hilo_out` is combinational from the HI/LO regs: sel 00 → HI, 01 → LO, otherwise 0. During RUN it shows the previous, stale HI/LO values.
- `hilo_stall` = `busy` AND (`hilo_sel` ∈ {00, 01}). Reads issued in the COMMIT cycle also stall. The pipeline holds the mfhi/mflo until the stall drops.
- Reset values:
  - State = IDLE, `cnt`=0, HI=0, LO=0.
  - rem/quo/divisor regs = 0.
  - `busy`=0, `done`=0, `hilo_stall`=0, `hilo_out`=0.
- Reset mid-operation aborts the division. HI/LO are cleared and are not partially written. `div_start` in the same cycle as `rst` is ignored.

## Timing
- Edge E0: `div_start`=1 while IDLE is accepted.
- Edges E1..E32: the 32 RUN steps (for WIDTH=32).
- Edge E33: HI/LO written.
- `busy` is high in the 33 cycles following E0, that is from after E0 through the COMMIT cycle. This matches the ALU control 33-count, so `busy` falls at the same edge `DIVOperation` clears.
- `done` is high during the cycle in which HI/LO are written, i.e. the COMMIT cycle. The new values are visible on `hilo_out` from the cycle after E33.
- A new `div_start` is accepted on the first cycle after COMMIT (back-to-back issue with no bubble).
- Counter width: $clog2(WIDTH)+1 bits. There is no wrap-around in RUN, since it exits at `cnt`==WIDTH−1 on the final step.

## Structure
- Shared package `mips_ex_pkg`:
  - HI/LO select localparams `HILO_HI`=2'b00, `HILO_LO`=2'b01, `HILO_NONE`=2'b10.
  - State encoding IDLE/RUN/COMMIT.
  - `DIV_CYCLES`=33.
- Sub-module `divu_step`: purely combinational single restoring iteration. Inputs rem, quo, divisor; outputs next rem, next quo. It is instantiated once and reused every RUN cycle.
- Top level: FSM, counter, operand/HI/LO registers, read mux, stall logic.

## Test plan
- 100 / 7: pulse `div_start`, then poll. `busy` is high for exactly 33 cycles and `done` pulses once. `hilo_sel`=01 reads 14; `hilo_sel`=00 reads 2.
- 0xFFFFFFFF / 1: LO = 0xFFFFFFFF and HI = 0. Then 5 / 0x80000000: LO = 0 and HI = 5.
- Divide by zero, 0x1234 / 0: LO = 0xFFFFFFFF and HI = 0x1234, with the normal 33-cycle timing.
- Hold `hilo_sel`=00 from cycle 1 of a division: `hilo_stall`=1 for 33 cycles and `hilo_out` shows the old HI. The stall drops together with `busy`, then the new HI appears. `hilo_sel`=10 never stalls.
- Assert `rst` in cycle 10 of 1000 / 3: the next cycle shows `busy`=0, HI=LO=0, and `done` never pulses. A fresh 9 / 2 afterwards gives LO=4, HI=1.
- `div_start` re-pulsed with different operands at cycle 5 of 50 / 5: the re-pulse is ignored and the result is LO=10, HI=0. Back-to-back 7 / 2 issued in the cycle after COMMIT is accepted immediately and gives LO=3, HI=1.
